seg7_to_binary_rx: RTL and testbench
====================================

// Module: seg7_to_binary_rx
// PURPOSE
//  Reverse path of our binary-to-seven-segment driver. Samples an external multiplexed
//  active-low 7-seg bus (segments + anodes) and recovers the 4-bit value per digit.
//  Qualifies each pattern for STABLE_CYCLES, keeps a per-digit shadow bank and streams
//  changes out over valid/ready. Sits between board display pins and the readback/test logic.
// PARAMETERS
//  NUM_DIGITS     4   number of multiplexed digits (anodes), >=1
//  STABLE_CYCLES  8   consecutive identical synchronized samples needed to accept, >=2
//  IDX_W          derived localparam = max(1,$clog2(NUM_DIGITS))
// PORTS
//  clk          in   1             single system clock, all logic on rising edge
//  rst_n        in   1             asynchronous, active-low reset
//  seg_in       in   [0:6]         segments a..g, bit0=a, active-low (0 = lit), asynchronous
//  an_in        in   [NUM_DIGITS-1:0] anode selects, active-low one-hot, asynchronous
//  out_valid    out  1             update available
//  out_ready    in   1             consumer accepts update when out_valid&&out_ready
//  out_digit    out  4             decoded value (0 when out_err)
//  out_index    out  IDX_W         digit position of the update
//  out_err      out  1             pattern not in decode table
//  digits_flat  out  4*NUM_DIGITS  shadow bank, digit i at [4i+3:4i]
//  digits_ok    out  NUM_DIGITS    1 = bank entry i holds a valid decode
//  overflow     out  1             sticky: update dropped while output stalled
// BEHAVIOUR
//  - Reset (async assert, sync release): sync flops -> seg 7'b1111111, an all-ones;
//    counter 0; out_valid/out_err/overflow 0; out_digit/out_index 0; bank 0; digits_ok 0.
//  - seg_in/an_in pass a 2-flop synchronizer -> sample s. Sample legal only if exactly
//    one an bit is 0; otherwise counter clears to 0 and nothing is accepted.
//  - Counter: legal s equal to previous s -> increment, saturate at STABLE_CYCLES;
//    s differs -> counter = 1. Accept pulse fires once, on the cycle the counter
//    transitions to STABLE_CYCLES. A held pattern never re-accepts.
//  - Decode (a..g, active-low): 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100
//    5=0100100 6=0100000 7=0001111 8=0000000 9=0000100; any other pattern
//    (incl. blank 1111111) -> err.
//  - On accept for index i: if (decode,err) differs from bank[i]/!digits_ok[i], bank
//    written next edge and an update {digit,i,err} generated; unchanged -> no update.
//  - Latency: pins stable before edge k -> out_valid high after edge k+STABLE_CYCLES+2.
//  - Output: out_valid/data registered, held stable until out_valid&&out_ready.
//    Handshake + new update same cycle -> new update loaded, out_valid stays 1.
//    New update while out_valid&&!out_ready -> update dropped (bank still written),
//    overflow set; overflow clears only on reset.
//  - FSM (output side): EMPTY (out_valid=0) -> FULL on update; FULL -> EMPTY on
//    handshake without update; FULL -> FULL on handshake+update or stall.
//  - Reset mid-qualification or mid-handshake discards everything; no partial update.
// CONFIGURATION
//  SEG7_RX_HEX_EN defined: also decodes A=0001000 b=1100000 C=0110001 d=1000010
//    E=0110000 F=0111000 as 4'hA..4'hF, out_err=0.
//  Not defined: those six patterns decode as err, like any unlisted pattern.
// TESTING
//  1 reset: rst_n low mid-stream -> all outputs 0 immediately, no update after release.
//  2 an=1110, seg=0010010 held 12 cycles, out_ready=1 -> one update digit=2 idx=0 err=0
//    at edge STABLE_CYCLES+2; digits_flat[3:0]=2; same pattern held longer -> no 2nd update.
//  3 pattern held only STABLE_CYCLES-1 cycles then changed -> no update; an=1100 -> no update.
//  4 out_ready=0, digit0=5 then digit1=7 accepted -> first update held, second dropped,
//    overflow=1, digits_flat[7:4]=7.
//  5 an=1011, seg=0001000 -> HEX_EN: digit=A err=0; without: err=1 digit=0, digits_ok[2]=0.
//  6 4-digit scan of 1,2,3,4 with 16-cycle dwell, ready tied high -> 4 updates, idx 0..3;
//    repeat scan -> no updates.

Source files
------------

// File: rtl/seg7_to_binary_rx.sv
// seg7_to_binary_rx: recovers per-digit 4-bit values from a multiplexed active-low 7-seg bus.
// Optional A..F decode is enabled by defining SEG7_RX_HEX_EN.
module seg7_to_binary_rx #(
    parameter  int NUM_DIGITS    = 4,
    parameter  int STABLE_CYCLES = 8,
    localparam int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [0:6]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [3:0]              out_digit,
    output logic [IDX_W-1:0]        out_index,
    output logic                    out_err,
    output logic [4*NUM_DIGITS-1:0] digits_flat,
    output logic [NUM_DIGITS-1:0]   digits_ok,
    output logic                    overflow
);

    localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam int SAMP_W = 7 + NUM_DIGITS;
`ifdef SEG7_RX_HEX_EN
    localparam bit HEX_EN = 1'b1;
`else
    localparam bit HEX_EN = 1'b0;
`endif

    typedef enum logic {ST_EMPTY, ST_FULL} out_state_e;

    // Returns {err, digit}; digit is 0 whenever err is set.
    function automatic logic [4:0] decode7(input logic [0:6] p);
        logic [4:0] r;
        case (p)
            7'b0000001: r = 5'h00;
            7'b1001111: r = 5'h01;
            7'b0010010: r = 5'h02;
            7'b0000110: r = 5'h03;
            7'b1001100: r = 5'h04;
            7'b0100100: r = 5'h05;
            7'b0100000: r = 5'h06;
            7'b0001111: r = 5'h07;
            7'b0000000: r = 5'h08;
            7'b0000100: r = 5'h09;
            default: begin
                r = 5'h10;
                if (HEX_EN) begin
                    case (p)
                        7'b0001000: r = 5'h0A;
                        7'b1100000: r = 5'h0B;
                        7'b0110001: r = 5'h0C;
                        7'b1000010: r = 5'h0D;
                        7'b0110000: r = 5'h0E;
                        7'b0111000: r = 5'h0F;
                        default:    r = 5'h10;
                    endcase
                end
            end
        endcase
        return r;
    endfunction

    // Reset asserts asynchronously but is released on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    logic [0:6]            seg_s1_q, seg_s2_q;
    logic [NUM_DIGITS-1:0] an_s1_q, an_s2_q;

    // NOTE: sequential state uses <= so both synchronizer stages sample pre-edge values;
    // with = the two flops would collapse into a single stage.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            seg_s1_q <= '1;
            seg_s2_q <= '1;
            an_s1_q  <= '1;
            an_s2_q  <= '1;
        end else begin
            seg_s1_q <= seg_in;
            seg_s2_q <= seg_s1_q;
            an_s1_q  <= an_in;
            an_s2_q  <= an_s1_q;
        end
    end

    logic [SAMP_W-1:0]     samp, prev_q;
    logic [NUM_DIGITS-1:0] an_low;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      s_idx;
    logic                  s_legal, s_same, accept;

    assign samp    = {seg_s2_q, an_s2_q};
    assign an_low  = ~an_s2_q;
    assign s_legal = (an_low != '0) && ((an_low & (an_low - NUM_DIGITS'(1))) == '0);
    assign s_same  = (samp == prev_q);
    assign accept  = s_legal && s_same && (cnt_q == CNT_W'(STABLE_CYCLES - 1));

    // NOTE: every variable here gets a default before any branch, so no path infers a latch.
    always_comb begin
        s_idx = '0;
        cnt_d = cnt_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an_low[i]) s_idx = IDX_W'(i);
        end
        if (!s_legal)                                cnt_d = '0;
        else if (!s_same)                            cnt_d = CNT_W'(1);
        else if (cnt_q != CNT_W'(STABLE_CYCLES))     cnt_d = cnt_q + CNT_W'(1);
    end

    logic             acc_q;
    logic [0:6]       acc_seg_q;
    logic [IDX_W-1:0] acc_idx_q;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            cnt_q     <= '0;
            prev_q    <= '1;
            acc_q     <= 1'b0;
            acc_seg_q <= '1;
            acc_idx_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            prev_q    <= samp;
            acc_q     <= accept;
            acc_seg_q <= seg_s2_q;
            acc_idx_q <= s_idx;
        end
    end

    logic [3:0]            bank_q [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] ok_q;
    logic [4:0]            dec;
    logic                  dec_err, cur_ok, changed, upd;
    logic [3:0]            dec_digit, cur_digit;

    assign dec       = decode7(acc_seg_q);
    assign dec_err   = dec[4];
    assign dec_digit = dec[3:0];
    assign cur_digit = bank_q[acc_idx_q];
    assign cur_ok    = ok_q[acc_idx_q];
    // An error entry is stored as (0, not ok), so only its ok bit needs comparing.
    assign changed   = dec_err ? cur_ok : (!cur_ok || (cur_digit != dec_digit));
    assign upd       = acc_q && changed;

    out_state_e       state_q, state_d;
    logic             load, ovf_set;
    logic [3:0]       out_digit_q;
    logic [IDX_W-1:0] out_index_q;
    logic             out_err_q, overflow_q;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        ovf_set = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (upd) begin
                    state_d = ST_FULL;
                    load    = 1'b1;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    if (upd) load = 1'b1;
                    else     state_d = ST_EMPTY;
                end else if (upd) begin
                    ovf_set = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // NOTE: the shadow bank is reset deliberately: digits_flat/digits_ok must read 0 out of
    // reset, so it is built from resettable flops rather than a RAM.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q     <= ST_EMPTY;
            out_digit_q <= '0;
            out_index_q <= '0;
            out_err_q   <= 1'b0;
            overflow_q  <= 1'b0;
            ok_q        <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) bank_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (upd) begin
                bank_q[acc_idx_q] <= dec_digit;
                ok_q[acc_idx_q]   <= !dec_err;
            end
            if (load) begin
                out_digit_q <= dec_digit;
                out_index_q <= acc_idx_q;
                out_err_q   <= dec_err;
            end
            if (ovf_set) overflow_q <= 1'b1;
        end
    end

    always_comb begin
        digits_flat = '0;
        for (int i = 0; i < NUM_DIGITS; i++) digits_flat[4*i +: 4] = bank_q[i];
    end

    assign digits_ok = ok_q;
    assign out_valid = (state_q == ST_FULL);
    assign out_digit = out_digit_q;
    assign out_index = out_index_q;
    assign out_err   = out_err_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_seg7_to_binary_rx.sv
// Scoreboard bench for seg7_to_binary_rx: stimulus pushes expected updates, a monitor pops
// them on every handshake. Honors SEG7_RX_HEX_EN the same way as the design.
module tb_seg7_to_binary_rx;

    localparam int ND = 4;
    localparam int SC = 8;

    typedef struct packed {
        logic [3:0] digit;
        logic [1:0] idx;
        logic       err;
    } upd_t;

    logic          clk;
    logic          rst_n;
    logic [0:6]    seg_in;
    logic [ND-1:0] an_in;
    logic          out_ready;
    logic          out_valid;
    logic [3:0]    out_digit;
    logic [1:0]    out_index;
    logic          out_err;
    logic [4*ND-1:0] digits_flat;
    logic [ND-1:0] digits_ok;
    logic          overflow;

    int   errors = 0;
    int   checks = 0;
    upd_t sb[$];

    seg7_to_binary_rx #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_digit   (out_digit),
        .out_index   (out_index),
        .out_err     (out_err),
        .digits_flat (digits_flat),
        .digits_ok   (digits_ok),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic expect_upd(input logic [3:0] d, input logic [1:0] i, input logic e);
        upd_t u;
        u.digit = d;
        u.idx   = i;
        u.err   = e;
        sb.push_back(u);
    endtask

    // Inputs change 2 time units after a rising edge; the monitor samples on falling edges.
    task automatic show(input logic [ND-1:0] an, input logic [0:6] seg, input int cycles);
        an_in  = an;
        seg_in = seg;
        repeat (cycles) begin
            @(posedge clk);
            #2;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_update: got digit=%0h idx=%0d err=%0b required none",
                         out_digit, out_index, out_err);
            end else begin
                upd_t e;
                e = sb.pop_front();
                check("upd_digit", 32'(out_digit), 32'(e.digit));
                check("upd_index", 32'(out_index), 32'(e.idx));
                check("upd_err",   32'(out_err),   32'(e.err));
            end
        end
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        seg_in    = 7'b1111111;
        an_in     = '1;
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        check("rst_valid",    32'(out_valid),   32'd0);
        check("rst_overflow", 32'(overflow),    32'd0);
        check("rst_flat",     32'(digits_flat), 32'd0);
        check("rst_ok",       32'(digits_ok),   32'd0);
        check("rst_digit",    32'(out_digit),   32'd0);
        check("rst_index",    32'(out_index),   32'd0);
        check("rst_err",      32'(out_err),     32'd0);
        show('1, 7'b1111111, 2);
        rst_n = 1'b1;
        show('1, 7'b1111111, 5);

        // Single digit 2 on position 0: latency, bank content, no re-accept while held.
        expect_upd(4'd2, 2'd0, 1'b0);
        an_in  = 4'b1110;
        seg_in = 7'b0010010;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        #1;
        check("latency_edges", 32'(n), 32'(SC + 3));
        show(4'b1110, 7'b0010010, 20);
        check("t2_flat0", 32'(digits_flat[3:0]), 32'd2);
        check("t2_ok0",   32'(digits_ok[0]),     32'd1);
        check("t2_sb_empty", 32'(sb.size()), 32'd0);

        // Held one cycle too short, then an illegal two-hot anode pattern.
        show(4'b1101, 7'b0000110, SC - 1);
        show(4'b1100, 7'b0000110, 20);
        check("t3_ok",       32'(digits_ok), 32'b0001);
        check("t3_sb_empty", 32'(sb.size()), 32'd0);

        // Stalled consumer: first update held, second dropped but still banked.
        out_ready = 1'b0;
        expect_upd(4'd5, 2'd0, 1'b0);
        show(4'b1110, 7'b0100100, 16);
        show(4'b1101, 7'b0001111, 16);
        check("t4_valid",    32'(out_valid),         32'd1);
        check("t4_held",     32'(out_digit),         32'd5);
        check("t4_overflow", 32'(overflow),          32'd1);
        check("t4_flat1",    32'(digits_flat[7:4]),  32'd7);
        check("t4_ok1",      32'(digits_ok[1]),      32'd1);
        out_ready = 1'b1;
        show(4'b1101, 7'b0001111, 3);
        check("t4_sb_empty", 32'(sb.size()), 32'd0);
        check("t4_ovf_sticky", 32'(overflow), 32'd1);

        // Digit 2 valid, then the 'A' pattern.
        expect_upd(4'd6, 2'd2, 1'b0);
        show(4'b1011, 7'b0100000, 16);
`ifdef SEG7_RX_HEX_EN
        expect_upd(4'hA, 2'd2, 1'b0);
        show(4'b1011, 7'b0001000, 16);
        check("t5_ok2",   32'(digits_ok[2]),      32'd1);
        check("t5_flat2", 32'(digits_flat[11:8]), 32'hA);
`else
        expect_upd(4'h0, 2'd2, 1'b1);
        show(4'b1011, 7'b0001000, 16);
        check("t5_ok2",   32'(digits_ok[2]),      32'd0);
        check("t5_flat2", 32'(digits_flat[11:8]), 32'h0);
`endif
        check("t5_sb_empty", 32'(sb.size()), 32'd0);

        // Full scan 1,2,3,4 then an identical rescan.
        expect_upd(4'd1, 2'd0, 1'b0);
        expect_upd(4'd2, 2'd1, 1'b0);
        expect_upd(4'd3, 2'd2, 1'b0);
        expect_upd(4'd4, 2'd3, 1'b0);
        for (int r = 0; r < 2; r++) begin
            show(4'b1110, 7'b1001111, 16);
            show(4'b1101, 7'b0010010, 16);
            show(4'b1011, 7'b0000110, 16);
            show(4'b0111, 7'b1001100, 16);
        end
        check("t6_flat",     32'(digits_flat), 32'h4321);
        check("t6_ok",       32'(digits_ok),   32'hF);
        check("t6_sb_empty", 32'(sb.size()),   32'd0);

        // Reset with a stalled update pending and another digit mid-qualification.
        out_ready = 1'b0;
        show(4'b1110, 7'b0000000, 16);
        check("t1_pending", 32'(out_valid), 32'd1);
        show(4'b1101, 7'b0000100, 5);
        rst_n  = 1'b0;
        an_in  = '1;
        seg_in = 7'b1111111;
        #1;
        check("t1_valid",    32'(out_valid),   32'd0);
        check("t1_flat",     32'(digits_flat), 32'd0);
        check("t1_ok",       32'(digits_ok),   32'd0);
        check("t1_overflow", 32'(overflow),    32'd0);
        check("t1_digit",    32'(out_digit),   32'd0);
        #1;
        show('1, 7'b1111111, 3);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        show('1, 7'b1111111, 30);
        check("t1_valid_after", 32'(out_valid), 32'd0);
        check("t1_ok_after",    32'(digits_ok), 32'd0);
        check("t1_sb_empty",    32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
